multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit; companion to the combinational ALU in the execute stage.
- Handles MIPS mul/div, which the single-cycle ALU cannot.
- Processor or bench issues a one-cycle start pulse with operands, then stalls until a one-cycle ready pulse returns result plus exception flag.
- Radix-2 shift-add multiply; restoring divide on magnitudes.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  one-cycle start pulse, multiply
ctrl_DIV  input  1  one-cycle start pulse, divide
data_result  output  WIDTH  product low word / quotient
data_exception  output  1  overflow or divide-by-zero, valid with ready
data_resultRDY  output  1  one-cycle pulse, result valid

Behaviour:
- Reset is sampled on the clock edge and overrides everything. State goes to IDLE; data_result=0, data_exception=0, data_resultRDY=0; counter and internal registers=0. Reset mid-operation aborts the op with no ready pulse.
- States and transitions:
  - IDLE: waits for a start pulse.
  - MULT / DIV: run for WIDTH cycles, then go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Start at edge E0:
  - Operands and op are latched at E0; later operand changes have no effect.
  - The counter loads 0.
  - One iteration is performed per edge, E1 through E32.
  - data_result, data_exception and data_resultRDY=1 are registered at edge E0+WIDTH+1 (latency 33 cycles).
  - data_resultRDY deasserts at the next edge.
- data_result and data_exception hold their values after ready until the next start or reset. They are not cleared by a start; they update only at the next completion.
- Start while busy (MULT/DIV/DONE) aborts the current op and restarts with the new operands; the aborted op produces no ready pulse.
- ctrl_MULT and ctrl_DIV high in the same cycle: ignored, no start; a busy op continues unaffected.
- Multiply:
  - Full 64-bit signed product is formed.
  - data_result = low 32 bits.
  - data_exception = 1 iff the high 32 bits are not the sign-extension of bit 31.
- Divide:
  - Signed, truncating toward zero; quotient sign = signA XOR signB; remainder discarded.
  - B=0: data_result=0, data_exception=1.
  - A=0x80000000 and B=0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - Magnitude of 0x80000000 is handled as unsigned 2^31; no internal overflow.
- Exception is 0 for all other cases.

Optional Feature:
MULTDIV_EARLY_DIV0_EN
- Defined:
  - A divide start with B==0 goes directly to DONE.
  - Ready, data_result=0 and data_exception=1 are registered at E0+1 (latency 1 cycle).
  - All other ops keep latency WIDTH+1.
- Undefined: divide-by-zero uses the full WIDTH+1 latency with the same result values.

Test Plan:
- Reset held 2 cycles, then released -> data_result=0, data_exception=0, data_resultRDY=0; no ready pulse within 40 idle cycles.
- ctrl_MULT with A=-7, B=6 -> exactly 33 cycles later: one-cycle ready, data_result=0xFFFFFFD6 (-42), exception=0. Then A=0x00010000, B=0x00010000 -> data_result=0, exception=1.
- ctrl_DIV with A=-17, B=5 -> data_result=0xFFFFFFFD (-3), exception=0. Then A=0x80000000, B=-1 -> data_result=0x80000000, exception=1.
- ctrl_DIV with A=123, B=0 -> data_result=0, exception=1. Ready comes after 33 cycles without the macro and after 1 cycle with MULTDIV_EARLY_DIV0_EN.
- ctrl_MULT A=3, B=4; 10 cycles later ctrl_DIV A=100, B=7 -> single ready pulse 33 cycles after the second start, data_result=14. Operands changed one cycle after a start do not alter the result.
- Reset at cycle 15 of a multiply -> no ready pulse; outputs 0. Simultaneous ctrl_MULT and ctrl_DIV from IDLE -> no ready pulse within 40 cycles.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// Handshake/operand bundle between the execute stage and multdiv_unit.
// The master drives operands and start pulses; the slave returns result, exception and ready.
interface multdiv_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) on operand magnitudes.
// Optional MULTDIV_EARLY_DIV0_EN: divide-by-zero skips the iterations and completes in one cycle.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input logic            clock,
   input logic            reset,
   multdiv_unit_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic              neg_q, neg_d;
   logic              div_q, div_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              exc_q, exc_d;
   logic              rdy_q, rdy_d;

   logic                 start_mult;
   logic                 start_div;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 last_iter;
   logic [WIDTH-1:0]     addend;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       rem_diff;
   logic                 rem_ge;
   logic [2*WIDTH-1:0]   prod_u;
   logic [2*WIDTH-1:0]   prod_s;
   logic                 mul_exc;
   logic [WIDTH-1:0]     quot_s;
   logic [WIDTH-1:0]     div_res;
   logic                 div_exc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mag_q    <= '0;
         neg_q    <= 1'b0;
         div_q    <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mag_q    <= mag_d;
         neg_q    <= neg_d;
         div_q    <= div_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   // Datapath helpers shared by both iteration kinds; hi/lo hold accumulator|multiplier
   // for multiply and remainder|dividend-shifting-into-quotient for divide.
   always_comb begin
      start_mult = bus.ctrl_MULT & ~bus.ctrl_DIV;
      start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;
      mag_a      = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
      mag_b      = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
      last_iter  = (cnt_q == CW'(WIDTH - 1));

      addend     = lo_q[0] ? mag_q : '0;
      add_sum    = {1'b0, hi_q} + {1'b0, addend};

      rem_sh     = {hi_q, lo_q[WIDTH-1]};
      rem_diff   = rem_sh - {1'b0, mag_q};
      rem_ge     = (rem_sh >= {1'b0, mag_q});

      prod_u     = {hi_q, lo_q};
      prod_s     = neg_q ? -prod_u : prod_u;
      mul_exc    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

      quot_s     = neg_q ? -lo_q : lo_q;
      div_res    = div0_q ? '0 : quot_s;
      div_exc    = div0_q | ovf_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mag_d    = mag_q;
      neg_d    = neg_q;
      div_d    = div_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      case (state_q)
         S_MULT: begin
            hi_d  = add_sum[WIDTH:1];
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) state_d = S_DONE;
         end
         S_DIV: begin
            hi_d  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], rem_ge};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) state_d = S_DONE;
         end
         S_DONE: begin
            result_d = div_q ? div_res : prod_s[WIDTH-1:0];
            exc_d    = div_q ? div_exc : mul_exc;
            rdy_d    = 1'b1;
            state_d  = S_IDLE;
         end
         default: ;
      endcase

      // A start from any state wins, so an op caught in DONE is dropped without a ready pulse.
      if (start_mult || start_div) begin
         state_d  = start_div ? S_DIV : S_MULT;
         cnt_d    = '0;
         hi_d     = '0;
         lo_d     = start_div ? mag_a : mag_b;
         mag_d    = start_div ? mag_b : mag_a;
         neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         div_d    = start_div;
         div0_d   = (bus.data_operandB == '0);
         ovf_d    = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (bus.data_operandB == '1);
         result_d = result_q;
         exc_d    = exc_q;
         rdy_d    = 1'b0;
`ifdef MULTDIV_EARLY_DIV0_EN
         if (start_div && (bus.data_operandB == '0)) state_d = S_DONE;
`else
`endif
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed plus randomized checks of multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;
   localparam int W = 32;
`ifdef MULTDIV_EARLY_DIV0_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   multdiv_unit_if #(.WIDTH(W)) bus ();
   multdiv_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
      end
   endtask

   function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint sa, sb, p, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         p = sa * sb;
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         q = sa / sb;
         r = q[31:0];
         e = 1'b0;
      end
   endfunction

   task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = ~is_div;
      bus.ctrl_DIV      = is_div;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
   endtask

   task automatic no_ready(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (bus.data_resultRDY) seen++;
      end
      chk(tag, "ready_cnt", seen, 0);
   endtask

   // Operands are scrambled one cycle after start; both_at > 0 pulses both controls mid-op.
   task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                         input logic [31:0] b, input int both_at);
      logic [31:0] er;
      logic        ee;
      int          k = 0;
      bit          got = 0;
      int          lat;
      model(is_div, a, b, er, ee);
      lat = (is_div && b == 32'd0) ? DIV0_LAT : 33;
      issue(is_div, a, b);
      while (!got && k < 60) begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
         end
         if (both_at > 0 && k == both_at) begin
            bus.ctrl_MULT = 1'b1;
            bus.ctrl_DIV  = 1'b1;
         end else begin
            bus.ctrl_MULT = 1'b0;
            bus.ctrl_DIV  = 1'b0;
         end
         if (bus.data_resultRDY) got = 1;
      end
      chk(tag, "latency", k, lat);
      chk(tag, "result", bus.data_result, er);
      chk(tag, "exception", {31'd0, bus.data_exception}, {31'd0, ee});
      @(negedge clock);
      chk(tag, "ready_drop", {31'd0, bus.data_resultRDY}, 32'd0);
      chk(tag, "result_hold", bus.data_result, er);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd0;
         4: return 32'($urandom_range(0, 40)) - 32'd20;
         default: return 32'h7FFF_FFFF;
      endcase
   endfunction

   initial begin
      logic [31:0] ra, rb;
      logic        rop;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      reset             = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("reset", "result", bus.data_result, 32'd0);
      chk("reset", "exception", {31'd0, bus.data_exception}, 32'd0);
      chk("reset", "ready", {31'd0, bus.data_resultRDY}, 32'd0);
      no_ready("idle", 40);

      run_op("mul_neg", 1'b0, -32'sd7, 32'sd6, 0);
      run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
      run_op("div_neg", 1'b1, -32'sd17, 32'sd5, 0);
      run_op("div_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_zero", 1'b1, 32'd123, 32'd0, 0);
      run_op("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mul_both", 1'b0, 32'd1234, -32'sd99, 5);

      issue(1'b0, 32'd3, 32'd4);
      no_ready("abort_gap", 9);
      run_op("abort_div", 1'b1, 32'd100, 32'd7, 0);

      issue(1'b0, 32'd5, 32'd9);
      repeat (14) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_reset", "result", bus.data_result, 32'd0);
      chk("mid_reset", "exception", {31'd0, bus.data_exception}, 32'd0);
      chk("mid_reset", "ready", {31'd0, bus.data_resultRDY}, 32'd0);
      no_ready("mid_reset", 40);

      @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      bus.ctrl_DIV  = 1'b1;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      no_ready("both_idle", 40);

      for (int i = 0; i < 24; i++) begin
         ra  = pick();
         rb  = pick();
         rop = 1'($urandom_range(0, 1));
         run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
